// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the memory-mapped UART.
//   - register word offsets (bus addr[3:2])
//   - STATUS bit positions
//   - TX / RX state encodings
//   - pack_status(): assembles the STATUS read word
package uart_pkg;

   // Register word offsets
   localparam logic [1:0] UART_TXDATA = 2'd0;
   localparam logic [1:0] UART_RXDATA = 2'd1;
   localparam logic [1:0] UART_STATUS = 2'd2;
   localparam logic [1:0] UART_CTRL   = 2'd3;

   // STATUS bit positions; [1:0] keep the legacy meaning (TX ready, RX present)
   localparam int ST_TX_NOTFULL  = 0;
   localparam int ST_RX_NONEMPTY = 1;
   localparam int ST_TX_EMPTY    = 2;
   localparam int ST_OVERRUN     = 3;
   localparam int ST_FRAME_ERR   = 4;
   localparam int ST_TX_DROP     = 5;

   typedef enum logic [1:0] {
      TX_IDLE  = 2'd0,
      TX_START = 2'd1,
      TX_DATA  = 2'd2,
      TX_STOP  = 2'd3
   } tx_state_e;

   typedef enum logic [1:0] {
      RX_IDLE  = 2'd0,
      RX_START = 2'd1,
      RX_DATA  = 2'd2,
      RX_STOP  = 2'd3
   } rx_state_e;

   function automatic logic [31:0] pack_status(
      input logic tx_drop,
      input logic frame_err,
      input logic overrun,
      input logic tx_empty,
      input logic rx_nonempty,
      input logic tx_notfull
   );
      logic [31:0] word;
      word                 = 32'd0;
      word[ST_TX_DROP]     = tx_drop;
      word[ST_FRAME_ERR]   = frame_err;
      word[ST_OVERRUN]     = overrun;
      word[ST_TX_EMPTY]    = tx_empty;
      word[ST_RX_NONEMPTY] = rx_nonempty;
      word[ST_TX_NOTFULL]  = tx_notfull;
      return word;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with first-word-fall-through head.
// Ports:
//   clk, rst       clock, synchronous active-high reset (pointers only)
//   push, wdata    write request and data; ignored when full unless popping
//   pop            read request; ignored when empty
//   head           oldest entry (valid when !empty)
//   full, empty    occupancy flags
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int AW    = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty
);

   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   logic [WIDTH-1:0] mem_r [0:(1<<AW)-1];
   logic [AW:0]      wr_ptr_r;
   logic [AW:0]      rd_ptr_r;
   logic             push_ok_s;
   logic             pop_ok_s;

   assign empty = (wr_ptr_r == rd_ptr_r);
   assign full  = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                  (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
   assign pop_ok_s  = pop & ~empty;
   // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
   assign push_ok_s = push & (~full | pop_ok_s);
   assign head      = mem_r[rd_ptr_r[AW-1:0]];

   // Pointer update.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_r <= {(AW+1){1'b0}};
         rd_ptr_r <= {(AW+1){1'b0}};
      end else begin
         if (push_ok_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
         if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
   end

   // Storage write; contents need no reset since pointers gate visibility.
   always_ff @(posedge clk) begin
      if (push_ok_s) mem_r[wr_ptr_r[AW-1:0]] <= wdata;
   end

endmodule

// File: rtl/uart_fifo_mmio.sv
// uart_fifo_mmio: memory-mapped 8N1 UART with 16-deep TX/RX FIFOs.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   valid, write        bus request (decoder-qualified), 1 = write
//   wmask, wdata, addr  byte enables, write data, word offset
//   rdata               registered read data, valid the cycle after the request
//   uart_rx             asynchronous serial input
//   uart_tx             registered serial output, idle high
//   irq                 registered level interrupt
// Map: 0 TXDATA, 1 RXDATA (pop on read), 2 STATUS (W1C flags [5:3]),
//      3 CTRL {tx_ie, rx_ie, DIV[15:0]}. Bit period is DIV+1 clocks.
module uart_fifo_mmio #(
   parameter int CLOCK_RATE = 12_000_000,
   parameter int BAUD_RATE  = 115200,
   parameter int TX_AW      = 4,
   parameter int RX_AW      = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        valid,
   input  logic        write,
   input  logic [3:0]  wmask,
   input  logic [31:0] wdata,
   input  logic [1:0]  addr,
   output logic [31:0] rdata,
   input  logic        uart_rx,
   output logic        uart_tx,
   output logic        irq
);
   import uart_pkg::*;

   localparam logic [15:0] DIV_RESET = 16'(CLOCK_RATE / BAUD_RATE - 1);

   // Bus decode
   logic bus_wr_s, bus_rd_s, ctrl_wr_s, w1c_s;
   assign bus_wr_s  = valid & write;
   assign bus_rd_s  = valid & ~write;
   assign ctrl_wr_s = bus_wr_s & (addr == UART_CTRL);
   assign w1c_s     = bus_wr_s & (addr == UART_STATUS) & wmask[0];

   logic unused_s;
   assign unused_s = ^{wdata[31:18], wmask[3]};

   // Control / status registers
   logic [15:0] div_r;
   logic        rx_ie_r, tx_ie_r;
   logic        tx_drop_r, frame_err_r, overrun_r;
   logic [31:0] rdata_r, rdata_nx_s;
   logic        irq_r;

   // FIFOs
   logic       tx_push_s, tx_pop_s, tx_full_s, tx_empty_s;
   logic [7:0] tx_head_s;
   logic       rx_push_s, rx_pop_s, rx_full_s, rx_empty_s;
   logic [7:0] rx_head_s;

   assign tx_push_s = bus_wr_s & (addr == UART_TXDATA) & wmask[0];
   assign rx_pop_s  = bus_rd_s & (addr == UART_RXDATA) & ~rx_empty_s;

   sync_fifo #(.WIDTH(8), .AW(TX_AW)) u_tx_fifo (
      .clk(clk), .rst(rst), .push(tx_push_s), .pop(tx_pop_s),
      .wdata(wdata[7:0]), .head(tx_head_s), .full(tx_full_s), .empty(tx_empty_s)
   );

   // TX datapath/FSM state
   tx_state_e   tx_state_r, tx_state_nx_s;
   logic [15:0] tx_cnt_r, tx_cnt_nx_s;
   logic [2:0]  tx_bit_r, tx_bit_nx_s;
   logic [7:0]  tx_shift_r, tx_shift_nx_s;
   logic        uart_tx_r, uart_tx_nx_s;

   // TX next-state: each state holds its line level for div_r+1 cycles.
   always_comb begin
      tx_state_nx_s = tx_state_r;
      tx_cnt_nx_s   = tx_cnt_r;
      tx_bit_nx_s   = tx_bit_r;
      tx_shift_nx_s = tx_shift_r;
      uart_tx_nx_s  = uart_tx_r;
      tx_pop_s      = 1'b0;
      case (tx_state_r)
         TX_IDLE: begin
            if (!tx_empty_s) begin
               tx_pop_s      = 1'b1;
               tx_shift_nx_s = tx_head_s;
               tx_cnt_nx_s   = div_r;
               uart_tx_nx_s  = 1'b0;
               tx_state_nx_s = TX_START;
            end else begin
               uart_tx_nx_s  = 1'b1;
            end
         end
         TX_START: begin
            if (tx_cnt_r == 16'd0) begin
               tx_cnt_nx_s   = div_r;
               tx_bit_nx_s   = 3'd0;
               uart_tx_nx_s  = tx_shift_r[0];
               tx_shift_nx_s = {1'b0, tx_shift_r[7:1]};
               tx_state_nx_s = TX_DATA;
            end else begin
               tx_cnt_nx_s   = tx_cnt_r - 16'd1;
            end
         end
         TX_DATA: begin
            if (tx_cnt_r == 16'd0) begin
               tx_cnt_nx_s = div_r;
               if (tx_bit_r == 3'd7) begin
                  uart_tx_nx_s  = 1'b1;
                  tx_state_nx_s = TX_STOP;
               end else begin
                  tx_bit_nx_s   = tx_bit_r + 3'd1;
                  uart_tx_nx_s  = tx_shift_r[0];
                  tx_shift_nx_s = {1'b0, tx_shift_r[7:1]};
               end
            end else begin
               tx_cnt_nx_s = tx_cnt_r - 16'd1;
            end
         end
         TX_STOP: begin
            if (tx_cnt_r == 16'd0) begin
               // Chain straight into the next start bit when more data waits.
               if (!tx_empty_s) begin
                  tx_pop_s      = 1'b1;
                  tx_shift_nx_s = tx_head_s;
                  tx_cnt_nx_s   = div_r;
                  uart_tx_nx_s  = 1'b0;
                  tx_state_nx_s = TX_START;
               end else begin
                  uart_tx_nx_s  = 1'b1;
                  tx_state_nx_s = TX_IDLE;
               end
            end else begin
               tx_cnt_nx_s = tx_cnt_r - 16'd1;
            end
         end
         default: begin
            uart_tx_nx_s  = 1'b1;
            tx_state_nx_s = TX_IDLE;
         end
      endcase
   end

   // TX state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         tx_state_r <= TX_IDLE;
         tx_cnt_r   <= 16'd0;
         tx_bit_r   <= 3'd0;
         tx_shift_r <= 8'd0;
         uart_tx_r  <= 1'b1;
      end else begin
         tx_state_r <= tx_state_nx_s;
         tx_cnt_r   <= tx_cnt_nx_s;
         tx_bit_r   <= tx_bit_nx_s;
         tx_shift_r <= tx_shift_nx_s;
         uart_tx_r  <= uart_tx_nx_s;
      end
   end

   // RX synchroniser and FSM state
   logic        rx_meta_r, rx_sync_r;
   rx_state_e   rx_state_r, rx_state_nx_s;
   logic [15:0] rx_cnt_r, rx_cnt_nx_s;
   logic [2:0]  rx_bit_r, rx_bit_nx_s;
   logic [7:0]  rx_shift_r, rx_shift_nx_s;
   logic        frame_err_set_s, overrun_set_s, tx_drop_set_s;

   sync_fifo #(.WIDTH(8), .AW(RX_AW)) u_rx_fifo (
      .clk(clk), .rst(rst), .push(rx_push_s), .pop(rx_pop_s),
      .wdata(rx_shift_r), .head(rx_head_s), .full(rx_full_s), .empty(rx_empty_s)
   );

   // RX next-state: half-bit delay after the falling edge, then one sample per bit.
   always_comb begin
      rx_state_nx_s   = rx_state_r;
      rx_cnt_nx_s     = rx_cnt_r;
      rx_bit_nx_s     = rx_bit_r;
      rx_shift_nx_s   = rx_shift_r;
      rx_push_s       = 1'b0;
      frame_err_set_s = 1'b0;
      case (rx_state_r)
         RX_IDLE: begin
            if (!rx_sync_r) begin
               rx_cnt_nx_s   = {1'b0, div_r[15:1]};
               rx_state_nx_s = RX_START;
            end else begin
               rx_state_nx_s = RX_IDLE;
            end
         end
         RX_START: begin
            if (rx_cnt_r == 16'd0) begin
               // Line back high at mid start bit: treat as a glitch.
               if (!rx_sync_r) begin
                  rx_cnt_nx_s   = div_r;
                  rx_bit_nx_s   = 3'd0;
                  rx_state_nx_s = RX_DATA;
               end else begin
                  rx_state_nx_s = RX_IDLE;
               end
            end else begin
               rx_cnt_nx_s = rx_cnt_r - 16'd1;
            end
         end
         RX_DATA: begin
            if (rx_cnt_r == 16'd0) begin
               rx_cnt_nx_s   = div_r;
               rx_shift_nx_s = {rx_sync_r, rx_shift_r[7:1]};
               if (rx_bit_r == 3'd7) begin
                  rx_state_nx_s = RX_STOP;
               end else begin
                  rx_bit_nx_s   = rx_bit_r + 3'd1;
               end
            end else begin
               rx_cnt_nx_s = rx_cnt_r - 16'd1;
            end
         end
         RX_STOP: begin
            if (rx_cnt_r == 16'd0) begin
               rx_state_nx_s = RX_IDLE;
               if (rx_sync_r) begin
                  rx_push_s       = 1'b1;
               end else begin
                  frame_err_set_s = 1'b1;
               end
            end else begin
               rx_cnt_nx_s = rx_cnt_r - 16'd1;
            end
         end
         default: begin
            rx_state_nx_s = RX_IDLE;
         end
      endcase
   end

   // A drop only happens when full and the same cycle does not free a slot.
   assign overrun_set_s = rx_push_s & rx_full_s & ~rx_pop_s;
   assign tx_drop_set_s = tx_push_s & tx_full_s & ~tx_pop_s;

   // RX synchroniser and state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_meta_r  <= 1'b1;
         rx_sync_r  <= 1'b1;
         rx_state_r <= RX_IDLE;
         rx_cnt_r   <= 16'd0;
         rx_bit_r   <= 3'd0;
         rx_shift_r <= 8'd0;
      end else begin
         rx_meta_r  <= uart_rx;
         rx_sync_r  <= rx_meta_r;
         rx_state_r <= rx_state_nx_s;
         rx_cnt_r   <= rx_cnt_nx_s;
         rx_bit_r   <= rx_bit_nx_s;
         rx_shift_r <= rx_shift_nx_s;
      end
   end

   // Read mux: rdata only changes on a read request.
   always_comb begin
      rdata_nx_s = rdata_r;
      if (bus_rd_s) begin
         case (addr)
            UART_TXDATA: rdata_nx_s = 32'd0;
            UART_RXDATA: rdata_nx_s = rx_empty_s ? 32'd0 : {23'd0, 1'b1, rx_head_s};
            UART_STATUS: rdata_nx_s = pack_status(tx_drop_r, frame_err_r, overrun_r,
                                                  tx_empty_s, ~rx_empty_s, ~tx_full_s);
            UART_CTRL:   rdata_nx_s = {14'd0, tx_ie_r, rx_ie_r, div_r};
            default:     rdata_nx_s = 32'd0;
         endcase
      end else begin
         rdata_nx_s = rdata_r;
      end
   end

   // CTRL, sticky flags (set beats W1C), read data and interrupt.
   always_ff @(posedge clk) begin
      if (rst) begin
         div_r       <= DIV_RESET;
         rx_ie_r     <= 1'b0;
         tx_ie_r     <= 1'b0;
         tx_drop_r   <= 1'b0;
         frame_err_r <= 1'b0;
         overrun_r   <= 1'b0;
         rdata_r     <= 32'd0;
         irq_r       <= 1'b0;
      end else begin
         if (ctrl_wr_s & wmask[0]) div_r[7:0]  <= wdata[7:0];
         if (ctrl_wr_s & wmask[1]) div_r[15:8] <= wdata[15:8];
         if (ctrl_wr_s & wmask[2]) begin
            rx_ie_r <= wdata[16];
            tx_ie_r <= wdata[17];
         end
         tx_drop_r   <= tx_drop_set_s   | (tx_drop_r   & ~(w1c_s & wdata[ST_TX_DROP]));
         frame_err_r <= frame_err_set_s | (frame_err_r & ~(w1c_s & wdata[ST_FRAME_ERR]));
         overrun_r   <= overrun_set_s   | (overrun_r   & ~(w1c_s & wdata[ST_OVERRUN]));
         rdata_r     <= rdata_nx_s;
         irq_r       <= (rx_ie_r & ~rx_empty_s) | (tx_ie_r & tx_empty_s);
      end
   end

   assign rdata   = rdata_r;
   assign uart_tx = uart_tx_r;
   assign irq     = irq_r;

endmodule

// File: tb/tb_uart_fifo_mmio.sv
// Directed testbench for uart_fifo_mmio. Inputs change on the falling edge,
// outputs are sampled on the falling edge.
module tb_uart_fifo_mmio;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        valid = 1'b0;
   logic        write = 1'b0;
   logic [3:0]  wmask = 4'd0;
   logic [31:0] wdata = 32'd0;
   logic [1:0]  addr = 2'd0;
   logic [31:0] rdata;
   logic        uart_rx = 1'b1;
   logic        uart_tx;
   logic        irq;

   int n_vec = 0;
   int n_err = 0;

   uart_fifo_mmio dut (
      .clk(clk), .rst(rst), .valid(valid), .write(write), .wmask(wmask),
      .wdata(wdata), .addr(addr), .rdata(rdata), .uart_rx(uart_rx),
      .uart_tx(uart_tx), .irq(irq)
   );

   always #5 clk = ~clk;

   task automatic bus_write(input logic [1:0] a, input logic [31:0] d, input logic [3:0] m);
      @(negedge clk); valid = 1'b1; write = 1'b1; addr = a; wdata = d; wmask = m;
      @(negedge clk); valid = 1'b0; write = 1'b0; wmask = 4'd0;
   endtask

   task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
      @(negedge clk); valid = 1'b1; write = 1'b0; addr = a;
      @(negedge clk); valid = 1'b0; d = rdata;
   endtask

   task automatic apply_reset();
      @(negedge clk); rst = 1'b1; valid = 1'b0; uart_rx = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
   endtask

   // One 8N1 frame, p clocks per bit; line returns high afterwards.
   task automatic send_rx(input logic [7:0] b, input logic stop_bit, input int p);
      logic [9:0] frame;
      frame = {stop_bit, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         @(negedge clk); uart_rx = frame[i];
         repeat (p - 1) @(negedge clk);
      end
      @(negedge clk); uart_rx = 1'b1;
   endtask

   task automatic test_reset();
      logic [31:0] d;
      apply_reset();
      n_vec++; if (rdata !== 32'd0) begin n_err++; $display("FAIL reset_rdata: got %h expected %h", rdata, 32'd0); end
      n_vec++; if (uart_tx !== 1'b1) begin n_err++; $display("FAIL reset_uart_tx: got %b expected 1", uart_tx); end
      n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL reset_irq: got %b expected 0", irq); end
      bus_read(2'd2, d);
      n_vec++; if (d !== 32'h05) begin n_err++; $display("FAIL reset_status: got %h expected %h", d, 32'h05); end
      bus_read(2'd3, d);
      n_vec++; if (d !== 32'h67) begin n_err++; $display("FAIL reset_ctrl: got %h expected %h", d, 32'h67); end
      bus_write(2'd1, 32'hFF, 4'hF);
      n_vec++; if (rdata !== 32'h67) begin n_err++; $display("FAIL rdata_hold: got %h expected %h", rdata, 32'h67); end
      bus_read(2'd1, d);
      n_vec++; if (d !== 32'd0) begin n_err++; $display("FAIL rxdata_empty: got %h expected %h", d, 32'd0); end
      bus_read(2'd0, d);
      n_vec++; if (d !== 32'd0) begin n_err++; $display("FAIL txdata_read: got %h expected %h", d, 32'd0); end
   endtask

   task automatic test_tx_frame();
      logic [7:0] b;
      logic       e;
      b = 8'h55;
      bus_write(2'd3, 32'h0000_0003, 4'b0011);
      bus_write(2'd0, 32'h55, 4'b0001);
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (i < 4)       e = 1'b0;
         else if (i < 36) e = b[(i - 4) / 4];
         else             e = 1'b1;
         n_vec++;
         if (uart_tx !== e) begin n_err++; $display("FAIL tx_frame cycle %0d: got %b expected %b", i, uart_tx, e); end
      end
      repeat (4) @(negedge clk);
      n_vec++; if (uart_tx !== 1'b1) begin n_err++; $display("FAIL tx_idle_after: got %b expected 1", uart_tx); end
   endtask

   task automatic test_tx_fifo_full();
      logic [31:0] d;
      bus_write(2'd3, 32'h0000_1000, 4'b0011);
      // 17 back-to-back pushes; the first is popped by TX immediately.
      @(negedge clk); valid = 1'b1; write = 1'b1; addr = 2'd0; wmask = 4'b0001;
      for (int i = 0; i < 17; i++) begin
         wdata = 32'h40 + 32'(i);
         @(negedge clk);
      end
      valid = 1'b0; write = 1'b0; wmask = 4'd0;
      bus_read(2'd2, d);
      n_vec++; if (d !== 32'h00) begin n_err++; $display("FAIL fifo_full_status: got %h expected %h", d, 32'h00); end
      bus_write(2'd0, 32'h99, 4'b0001);
      bus_read(2'd2, d);
      n_vec++; if (d !== 32'h20) begin n_err++; $display("FAIL tx_drop_set: got %h expected %h", d, 32'h20); end
      bus_write(2'd2, 32'h20, 4'b0010);
      bus_read(2'd2, d);
      n_vec++; if (d !== 32'h20) begin n_err++; $display("FAIL w1c_unmasked: got %h expected %h", d, 32'h20); end
      bus_write(2'd2, 32'h20, 4'b0001);
      bus_read(2'd2, d);
      n_vec++; if (d !== 32'h00) begin n_err++; $display("FAIL tx_drop_clear: got %h expected %h", d, 32'h00); end
      apply_reset();
   endtask

   task automatic test_rx_frame();
      logic [31:0] d;
      bus_write(2'd3, 32'h0000_0007, 4'b0011);
      send_rx(8'hA3, 1'b1, 8);
      bus_read(2'd2, d);
      n_vec++; if (d !== 32'h07) begin n_err++; $display("FAIL rx_status_set: got %h expected %h", d, 32'h07); end
      bus_read(2'd1, d);
      n_vec++; if (d !== 32'h1A3) begin n_err++; $display("FAIL rx_data: got %h expected %h", d, 32'h1A3); end
      bus_read(2'd2, d);
      n_vec++; if (d !== 32'h05) begin n_err++; $display("FAIL rx_status_clr: got %h expected %h", d, 32'h05); end
   endtask

   task automatic test_frame_err();
      logic [31:0] d;
      send_rx(8'h5A, 1'b0, 8);
      repeat (10) @(negedge clk);
      bus_read(2'd2, d);
      n_vec++; if (d !== 32'h15) begin n_err++; $display("FAIL frame_err_set: got %h expected %h", d, 32'h15); end
      bus_write(2'd2, 32'h10, 4'b0001);
      bus_read(2'd2, d);
      n_vec++; if (d !== 32'h05) begin n_err++; $display("FAIL frame_err_clear: got %h expected %h", d, 32'h05); end
   endtask

   task automatic test_overrun();
      logic [31:0] d;
      for (int i = 0; i < 17; i++) send_rx(8'h30 + 8'(i), 1'b1, 8);
      bus_read(2'd2, d);
      n_vec++; if (d !== 32'h0F) begin n_err++; $display("FAIL overrun_status: got %h expected %h", d, 32'h0F); end
      for (int i = 0; i < 16; i++) begin
         bus_read(2'd1, d);
         n_vec++;
         if (d !== (32'h130 + 32'(i))) begin n_err++; $display("FAIL overrun_read %0d: got %h expected %h", i, d, 32'h130 + 32'(i)); end
      end
      bus_read(2'd1, d);
      n_vec++; if (d !== 32'd0) begin n_err++; $display("FAIL overrun_drained: got %h expected %h", d, 32'd0); end
      bus_read(2'd2, d);
      n_vec++; if (d !== 32'h0D) begin n_err++; $display("FAIL overrun_sticky: got %h expected %h", d, 32'h0D); end
      bus_write(2'd2, 32'h08, 4'b0001);
      bus_read(2'd2, d);
      n_vec++; if (d !== 32'h05) begin n_err++; $display("FAIL overrun_clear: got %h expected %h", d, 32'h05); end
   endtask

   task automatic test_irq();
      logic [31:0] d;
      apply_reset();
      bus_write(2'd3, 32'h0001_0007, 4'b0111);
      @(negedge clk);
      n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL irq_idle: got %b expected 0", irq); end
      send_rx(8'h3C, 1'b1, 8);
      n_vec++; if (irq !== 1'b1) begin n_err++; $display("FAIL irq_rx: got %b expected 1", irq); end
      bus_read(2'd1, d);
      n_vec++; if (d !== 32'h13C) begin n_err++; $display("FAIL irq_rx_data: got %h expected %h", d, 32'h13C); end
      @(negedge clk);
      n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL irq_after_pop: got %b expected 0", irq); end
      bus_write(2'd3, 32'h0002_FFFF, 4'b0100);
      @(negedge clk);
      n_vec++; if (irq !== 1'b1) begin n_err++; $display("FAIL irq_tx_empty: got %b expected 1", irq); end
      bus_read(2'd3, d);
      n_vec++; if (d !== 32'h0002_0007) begin n_err++; $display("FAIL ctrl_bytemask: got %h expected %h", d, 32'h0002_0007); end
   endtask

   task automatic test_reset_mid_tx();
      logic [31:0] d;
      bus_write(2'd0, 32'h00, 4'b0001);
      repeat (12) @(negedge clk);
      n_vec++; if (uart_tx !== 1'b0) begin n_err++; $display("FAIL mid_tx_low: got %b expected 0", uart_tx); end
      rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      n_vec++; if (uart_tx !== 1'b1) begin n_err++; $display("FAIL rst_uart_tx: got %b expected 1", uart_tx); end
      n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL rst_irq: got %b expected 0", irq); end
      bus_read(2'd2, d);
      n_vec++; if (d !== 32'h05) begin n_err++; $display("FAIL rst_status: got %h expected %h", d, 32'h05); end
      bus_read(2'd3, d);
      n_vec++; if (d !== 32'h67) begin n_err++; $display("FAIL rst_ctrl: got %h expected %h", d, 32'h67); end
      repeat (20) @(negedge clk);
      n_vec++; if (uart_tx !== 1'b1) begin n_err++; $display("FAIL rst_tx_stays_idle: got %b expected 1", uart_tx); end
   endtask

   initial begin
      test_reset();
      test_tx_frame();
      test_tx_fifo_full();
      test_rx_frame();
      test_frame_err();
      test_overrun();
      test_irq();
      test_reset_mid_tx();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
